// File: rtl/calc_core.sv
// calc_core: calculator control FSM. Assembles decimal operands from key
// tokens, issues chained ALU requests and publishes display updates over
// a valid/ready handshake.
module calc_core #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_alu_valid,
    output logic [1:0]       o_alu_op,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    input  logic             i_alu_ready,
    input  logic             i_alu_done,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic             i_alu_err,
    output logic             o_disp_valid,
    output logic [WIDTH-1:0] o_disp_value,
    output logic             o_disp_err,
    input  logic             i_disp_ready
);

    typedef enum logic [2:0] {
        S_ENTER_A,
        S_OP_WAIT,
        S_ENTER_B,
        S_ALU_REQ,
        S_ALU_WAIT,
        S_RESULT,
        S_ERROR
    } state_t;

    // Operand entry runs in a widened domain so the *10+d result never wraps
    // before it is compared against the largest positive value.
    localparam int unsigned EXT_W = WIDTH + 5;
    localparam logic [EXT_W-1:0] MAX_EXT = (EXT_W'(1) << (WIDTH - 1)) - EXT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_a_q, acc_a_d;
    logic [WIDTH-1:0] acc_b_q, acc_b_d;
    logic [1:0]       pend_op_q, pend_op_d;
    logic [1:0]       next_op_q, next_op_d;
    logic             eq_q, eq_d;
    logic             ready_q, ready_d;
    logic             disp_dirty_q, disp_dirty_d;
    logic [WIDTH-1:0] disp_val_q, disp_val_d;
    logic             disp_err_q, disp_err_d;

    logic             tok_fire;
    logic             is_digit, is_ac, is_op, is_eq;
    logic [1:0]       tok_op;
    logic [WIDTH-1:0] digit_w;
    logic [EXT_W-1:0] digit_ext;
    logic [EXT_W-1:0] a_app, b_app;
    logic             a_fits, b_fits;
    logic [WIDTH-1:0] live_val;
    logic             live_err;
    logic             accept_state;

    // Token decode and saturating decimal append for both operands.
    always_comb begin
        tok_fire  = i_valid && ready_q;
        is_digit  = (i_data[4] == 1'b0) && (i_data[3:0] <= 4'd9);
        is_ac     = (i_data == 5'h10);
        is_op     = (i_data >= 5'h11) && (i_data <= 5'h14);
        is_eq     = (i_data == 5'h15);
        tok_op    = i_data[1:0] - 2'd1;
        digit_w   = {{(WIDTH-4){1'b0}}, i_data[3:0]};
        digit_ext = {{(EXT_W-4){1'b0}}, i_data[3:0]};
        a_app     = EXT_W'(acc_a_q) * EXT_W'(10) + digit_ext;
        b_app     = EXT_W'(acc_b_q) * EXT_W'(10) + digit_ext;
        a_fits    = (a_app <= MAX_EXT);
        b_fits    = (b_app <= MAX_EXT);
    end

    // Next-state logic for the control FSM and its operand registers.
    always_comb begin
        state_d   = state_q;
        acc_a_d   = acc_a_q;
        acc_b_d   = acc_b_q;
        pend_op_d = pend_op_q;
        next_op_d = next_op_q;
        eq_d      = eq_q;
        if (tok_fire && is_ac) begin
            acc_a_d   = '0;
            acc_b_d   = '0;
            pend_op_d = '0;
            state_d   = S_ENTER_A;
        end else begin
            case (state_q)
                S_ENTER_A: begin
                    if (tok_fire && is_digit) begin
                        if (a_fits) acc_a_d = a_app[WIDTH-1:0];
                    end else if (tok_fire && is_op) begin
                        pend_op_d = tok_op;
                        state_d   = S_OP_WAIT;
                    end
                end
                S_OP_WAIT: begin
                    if (tok_fire && is_digit) begin
                        acc_b_d = digit_w;
                        state_d = S_ENTER_B;
                    end else if (tok_fire && is_op) begin
                        pend_op_d = tok_op;
                    end
                end
                S_ENTER_B: begin
                    if (tok_fire && is_digit) begin
                        if (b_fits) acc_b_d = b_app[WIDTH-1:0];
                    end else if (tok_fire && is_op) begin
                        next_op_d = tok_op;
                        eq_d      = 1'b0;
                        state_d   = S_ALU_REQ;
                    end else if (tok_fire && is_eq) begin
                        eq_d    = 1'b1;
                        state_d = S_ALU_REQ;
                    end
                end
                S_ALU_REQ: begin
                    if (i_alu_ready) state_d = S_ALU_WAIT;
                end
                S_ALU_WAIT: begin
                    if (i_alu_done) begin
                        if (i_alu_err) begin
                            state_d = S_ERROR;
                        end else begin
                            acc_a_d = i_alu_result;
                            if (eq_q) begin
                                state_d = S_RESULT;
                            end else begin
                                pend_op_d = next_op_q;
                                state_d   = S_OP_WAIT;
                            end
                        end
                    end
                end
                S_RESULT: begin
                    if (tok_fire && is_digit) begin
                        acc_a_d = digit_w;
                        state_d = S_ENTER_A;
                    end else if (tok_fire && is_op) begin
                        pend_op_d = tok_op;
                        state_d   = S_OP_WAIT;
                    end
                end
                S_ERROR: begin
                    state_d = S_ERROR;
                end
                default: begin
                    state_d = S_ENTER_A;
                end
            endcase
        end
    end

    // Display tracking: compare against the next-state view so an update is
    // flagged in the same cycle the registers change; shown value is frozen
    // while an update waits for the driver.
    always_comb begin
        live_val     = (state_d == S_ENTER_B) ? acc_b_d : acc_a_d;
        live_err     = (state_d == S_ERROR);
        disp_val_d   = disp_val_q;
        disp_err_d   = disp_err_q;
        disp_dirty_d = disp_dirty_q;
        if (!(disp_dirty_q && !i_disp_ready)) begin
            if ((live_val != disp_val_q) || (live_err != disp_err_q)) begin
                disp_val_d   = live_val;
                disp_err_d   = live_err;
                disp_dirty_d = 1'b1;
            end else begin
                disp_dirty_d = 1'b0;
            end
        end
        accept_state = (state_d == S_ENTER_A) || (state_d == S_OP_WAIT) ||
                       (state_d == S_ENTER_B) || (state_d == S_RESULT)  ||
                       (state_d == S_ERROR);
        ready_d      = accept_state && !disp_dirty_d && !tok_fire;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_ENTER_A;
            acc_a_q      <= '0;
            acc_b_q      <= '0;
            pend_op_q    <= '0;
            next_op_q    <= '0;
            eq_q         <= 1'b0;
            ready_q      <= 1'b0;
            disp_dirty_q <= 1'b1;
            disp_val_q   <= '0;
            disp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_a_q      <= acc_a_d;
            acc_b_q      <= acc_b_d;
            pend_op_q    <= pend_op_d;
            next_op_q    <= next_op_d;
            eq_q         <= eq_d;
            ready_q      <= ready_d;
            disp_dirty_q <= disp_dirty_d;
            disp_val_q   <= disp_val_d;
            disp_err_q   <= disp_err_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_alu_valid  = (state_q == S_ALU_REQ);
    assign o_alu_op     = pend_op_q;
    assign o_alu_a      = acc_a_q;
    assign o_alu_b      = acc_b_q;
    assign o_disp_valid = disp_dirty_q;
    assign o_disp_value = disp_val_q;
    assign o_disp_err   = disp_err_q;

endmodule

// File: tb/tb_calc_core.sv
// Directed bench for calc_core: token sequences with hand-computed
// display and ALU request expectations.
module tb_calc_core;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [4:0]   i_data;
    logic         i_valid;
    logic         o_ready;
    logic         o_alu_valid;
    logic [1:0]   o_alu_op;
    logic [W-1:0] o_alu_a, o_alu_b;
    logic         i_alu_ready, i_alu_done, i_alu_err;
    logic [W-1:0] i_alu_result;
    logic         o_disp_valid;
    logic [W-1:0] o_disp_value;
    logic         o_disp_err;
    logic         i_disp_ready;

    int checks = 0;
    int errors = 0;

    logic [1:0]   cap_op;
    logic [W-1:0] cap_a, cap_b;

    calc_core #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
        .o_alu_valid(o_alu_valid), .o_alu_op(o_alu_op), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
        .i_alu_ready(i_alu_ready), .i_alu_done(i_alu_done), .i_alu_result(i_alu_result),
        .i_alu_err(i_alu_err), .o_disp_valid(o_disp_valid), .o_disp_value(o_disp_value),
        .o_disp_err(o_disp_err), .i_disp_ready(i_disp_ready)
    );

    always #5 clk = ~clk;

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_tok(input logic [4:0] d);
        int n = 0;
        @(negedge clk);
        while (o_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL send_tok_timeout: token %h, o_ready=%b required 1", d, o_ready);
        end else begin
            i_valid = 1'b1;
            i_data  = d;
            @(negedge clk);
            i_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(o_ready === 1'b1 && o_disp_valid === 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL wait_idle_timeout: o_ready=%b o_disp_valid=%b required 1/0", o_ready, o_disp_valid);
        end
    endtask

    // ALU model: delays acceptance two cycles, then answers after two more.
    task automatic serve_alu(input logic [W-1:0] res, input logic err,
                             output logic [1:0] op, output logic [W-1:0] a, output logic [W-1:0] b);
        int n = 0;
        op = '0; a = '0; b = '0;
        @(negedge clk);
        while (o_alu_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL alu_req_timeout: o_alu_valid=%b required 1", o_alu_valid);
        end else begin
            repeat (2) @(negedge clk);
            op = o_alu_op; a = o_alu_a; b = o_alu_b;
            i_alu_ready = 1'b1;
            @(negedge clk);
            i_alu_ready = 1'b0;
            repeat (2) @(negedge clk);
            i_alu_done   = 1'b1;
            i_alu_result = res;
            i_alu_err    = err;
            @(negedge clk);
            i_alu_done   = 1'b0;
            i_alu_err    = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", o_ready); end
        checks++; if (o_alu_valid !== 1'b0) begin errors++; $display("FAIL rst_alu_valid: got %b expected 0", o_alu_valid); end
        checks++; if (o_alu_op !== 2'b00) begin errors++; $display("FAIL rst_alu_op: got %b expected 00", o_alu_op); end
        checks++; if (o_alu_a !== 16'h0 || o_alu_b !== 16'h0) begin errors++; $display("FAIL rst_alu_ab: got %h/%h expected 0/0", o_alu_a, o_alu_b); end
        checks++; if (o_disp_value !== 16'h0 || o_disp_err !== 1'b0) begin errors++; $display("FAIL rst_disp: got %h err %b expected 0 err 0", o_disp_value, o_disp_err); end
        checks++; if (o_disp_valid !== 1'b1) begin errors++; $display("FAIL rst_disp_valid: got %b expected 1", o_disp_valid); end
        wait_idle();
        checks++; if (o_disp_value !== 16'h0) begin errors++; $display("FAIL rst_idle_disp: got %h expected 0", o_disp_value); end
    endtask

    task automatic test_add();
        send_tok(5'h01); send_tok(5'h02);
        wait_idle();
        checks++; if (o_disp_value !== 16'd12) begin errors++; $display("FAIL add_entry_a: got %0d expected 12", o_disp_value); end
        send_tok(5'h11); send_tok(5'h03); send_tok(5'h04);
        wait_idle();
        checks++; if (o_disp_value !== 16'd34) begin errors++; $display("FAIL add_entry_b: got %0d expected 34", o_disp_value); end
        send_tok(5'h15);
        serve_alu(16'd46, 1'b0, cap_op, cap_a, cap_b);
        checks++; if (cap_op !== 2'b00 || cap_a !== 16'd12 || cap_b !== 16'd34) begin errors++; $display("FAIL add_req: got op %b a %0d b %0d expected 00 12 34", cap_op, cap_a, cap_b); end
        wait_idle();
        checks++; if (o_disp_value !== 16'd46 || o_disp_err !== 1'b0) begin errors++; $display("FAIL add_result: got %0d err %b expected 46 err 0", o_disp_value, o_disp_err); end
    endtask

    task automatic test_sub_new_entry();
        send_tok(5'h10);
        send_tok(5'h07); send_tok(5'h12); send_tok(5'h09); send_tok(5'h15);
        serve_alu(16'hFFFE, 1'b0, cap_op, cap_a, cap_b);
        checks++; if (cap_op !== 2'b01 || cap_a !== 16'd7 || cap_b !== 16'd9) begin errors++; $display("FAIL sub_req: got op %b a %0d b %0d expected 01 7 9", cap_op, cap_a, cap_b); end
        wait_idle();
        checks++; if (o_disp_value !== 16'hFFFE || o_disp_err !== 1'b0) begin errors++; $display("FAIL sub_result: got %h err %b expected fffe err 0", o_disp_value, o_disp_err); end
        send_tok(5'h05);
        wait_idle();
        checks++; if (o_disp_value !== 16'd5) begin errors++; $display("FAIL sub_new_digit: got %0d expected 5", o_disp_value); end
        send_tok(5'h03);
        wait_idle();
        checks++; if (o_disp_value !== 16'd53) begin errors++; $display("FAIL sub_new_append: got %0d expected 53", o_disp_value); end
    endtask

    task automatic test_error();
        send_tok(5'h10);
        send_tok(5'h05); send_tok(5'h14); send_tok(5'h00); send_tok(5'h15);
        serve_alu(16'h0000, 1'b1, cap_op, cap_a, cap_b);
        checks++; if (cap_op !== 2'b11 || cap_a !== 16'd5 || cap_b !== 16'd0) begin errors++; $display("FAIL div_req: got op %b a %0d b %0d expected 11 5 0", cap_op, cap_a, cap_b); end
        wait_idle();
        checks++; if (o_disp_err !== 1'b1 || o_disp_value !== 16'd5) begin errors++; $display("FAIL err_show: got %0d err %b expected 5 err 1", o_disp_value, o_disp_err); end
        send_tok(5'h07); send_tok(5'h15); send_tok(5'h11);
        wait_idle();
        checks++; if (o_disp_err !== 1'b1 || o_disp_value !== 16'd5) begin errors++; $display("FAIL err_ignore: got %0d err %b expected 5 err 1", o_disp_value, o_disp_err); end
        send_tok(5'h10);
        wait_idle();
        checks++; if (o_disp_err !== 1'b0 || o_disp_value !== 16'd0) begin errors++; $display("FAIL err_clear: got %0d err %b expected 0 err 0", o_disp_value, o_disp_err); end
        send_tok(5'h04);
        wait_idle();
        checks++; if (o_disp_value !== 16'd4) begin errors++; $display("FAIL err_after_ac: got %0d expected 4", o_disp_value); end
    endtask

    task automatic test_saturate();
        send_tok(5'h10);
        send_tok(5'h03); send_tok(5'h02); send_tok(5'h07); send_tok(5'h06);
        wait_idle();
        checks++; if (o_disp_value !== 16'd3276) begin errors++; $display("FAIL sat_four: got %0d expected 3276", o_disp_value); end
        send_tok(5'h08);
        wait_idle();
        checks++; if (o_disp_value !== 16'd3276) begin errors++; $display("FAIL sat_over: got %0d expected 3276", o_disp_value); end
        send_tok(5'h07);
        wait_idle();
        checks++; if (o_disp_value !== 16'd32767) begin errors++; $display("FAIL sat_max: got %0d expected 32767", o_disp_value); end
        send_tok(5'h00);
        wait_idle();
        checks++; if (o_disp_value !== 16'd32767) begin errors++; $display("FAIL sat_hold: got %0d expected 32767", o_disp_value); end
    endtask

    task automatic test_chain();
        send_tok(5'h10);
        send_tok(5'h02); send_tok(5'h11); send_tok(5'h03); send_tok(5'h13);
        serve_alu(16'd5, 1'b0, cap_op, cap_a, cap_b);
        checks++; if (cap_op !== 2'b00 || cap_a !== 16'd2 || cap_b !== 16'd3) begin errors++; $display("FAIL chain_req1: got op %b a %0d b %0d expected 00 2 3", cap_op, cap_a, cap_b); end
        wait_idle();
        checks++; if (o_disp_value !== 16'd5) begin errors++; $display("FAIL chain_mid: got %0d expected 5", o_disp_value); end
        send_tok(5'h11); send_tok(5'h1F); send_tok(5'h13);
        send_tok(5'h04); send_tok(5'h15);
        serve_alu(16'd20, 1'b0, cap_op, cap_a, cap_b);
        checks++; if (cap_op !== 2'b10 || cap_a !== 16'd5 || cap_b !== 16'd4) begin errors++; $display("FAIL chain_req2: got op %b a %0d b %0d expected 10 5 4", cap_op, cap_a, cap_b); end
        wait_idle();
        checks++; if (o_disp_value !== 16'd20) begin errors++; $display("FAIL chain_result: got %0d expected 20", o_disp_value); end
    endtask

    task automatic test_disp_hold();
        send_tok(5'h10);
        wait_idle();
        i_disp_ready = 1'b0;
        send_tok(5'h06);
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (o_ready !== 1'b0 || o_disp_valid !== 1'b1 || o_disp_value !== 16'd6) begin
                errors++;
                $display("FAIL hold_stall: got ready %b valid %b value %0d expected 0 1 6", o_ready, o_disp_valid, o_disp_value);
            end
        end
        i_disp_ready = 1'b1;
        wait_idle();
        checks++; if (o_disp_value !== 16'd6) begin errors++; $display("FAIL hold_release: got %0d expected 6", o_disp_value); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        send_tok(5'h10);
        send_tok(5'h01); send_tok(5'h12); send_tok(5'h02); send_tok(5'h15);
        @(negedge clk);
        while (o_alu_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++; if (o_alu_valid !== 1'b1) begin errors++; $display("FAIL mid_req: o_alu_valid got %b expected 1", o_alu_valid); end
        i_alu_ready = 1'b1;
        @(negedge clk);
        i_alu_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (o_ready !== 1'b0 || o_alu_valid !== 1'b0 || o_alu_op !== 2'b00) begin errors++; $display("FAIL mid_rst_ctl: got ready %b alu_valid %b op %b expected 0 0 00", o_ready, o_alu_valid, o_alu_op); end
        checks++; if (o_alu_a !== 16'h0 || o_alu_b !== 16'h0) begin errors++; $display("FAIL mid_rst_ab: got %h/%h expected 0/0", o_alu_a, o_alu_b); end
        checks++; if (o_disp_valid !== 1'b1 || o_disp_value !== 16'h0 || o_disp_err !== 1'b0) begin errors++; $display("FAIL mid_rst_disp: got valid %b value %h err %b expected 1 0 0", o_disp_valid, o_disp_value, o_disp_err); end
        i_alu_done   = 1'b1;
        i_alu_result = 16'd99;
        @(negedge clk);
        i_alu_done   = 1'b0;
        wait_idle();
        checks++; if (o_disp_value !== 16'h0 || o_disp_err !== 1'b0) begin errors++; $display("FAIL mid_late_done: got %0d err %b expected 0 err 0", o_disp_value, o_disp_err); end
        send_tok(5'h08); send_tok(5'h01);
        wait_idle();
        checks++; if (o_disp_value !== 16'd81) begin errors++; $display("FAIL mid_reentry: got %0d expected 81", o_disp_value); end
    endtask

    initial begin
        rst = 1'b1; i_data = '0; i_valid = 1'b0;
        i_alu_ready = 1'b0; i_alu_done = 1'b0; i_alu_err = 1'b0; i_alu_result = '0;
        i_disp_ready = 1'b1;
        test_reset();
        test_add();
        test_sub_new_entry();
        test_error();
        test_saturate();
        test_chain();
        test_disp_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_core.md
# calc_core

Calculator control FSM sitting between `button_reader` and the ALU and display shift-register stages. It consumes 5-bit key tokens over a valid/ready handshake and assembles decimal operands. It issues one ALU request per operation, with left-to-right chaining, and publishes every change of the displayed value to the output driver over a second valid/ready handshake.

## Interface
- `WIDTH`, 16: operand/result width, two's complement signed.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-high.
- `i_data`  in  5  key token from `button_reader`.
- `i_valid`  in  1  token valid.
- `o_ready`  out  1  core accepts token this cycle.
- `o_alu_valid`  out  1  ALU request valid.
- `o_alu_op`  out  2  00 add, 01 sub, 10 mul, 11 div.
- `o_alu_a`, `o_alu_b`  out  WIDTH  operands.
- `i_alu_ready`  in  1  ALU accepts request.
- `i_alu_done`  in  1  one-cycle pulse, result valid.
- `i_alu_result`  in  WIDTH  result.
- `i_alu_err`  in  1  overflow or divide-by-zero, qualified by `i_alu_done`.
- `o_disp_valid`  out  1  display update valid.
- `o_disp_value`  out  WIDTH  signed value to show.
- `o_disp_err`  out  1  show error indication.
- `i_disp_ready`  in  1  output driver accepts update.

## Operation
- Token transfer: `i_valid && o_ready` in the same cycle.
- Token map:
  - 0x00–0x09: digits 0–9.
  - 0x10: AC.
  - 0x11–0x14: add, sub, mul, div.
  - 0x15: EQ.
  - All other codes are accepted and ignored.
- Registers: `acc_a`, `acc_b`, `pend_op`, `disp_dirty`.
- States:
  - `ENTER_A`
    - digit: `acc_a = acc_a*10 + d`.
    - operator: store `pend_op`, go to `OP_WAIT`.
    - EQ: ignored.
  - `OP_WAIT`
    - digit: `acc_b = d`, go to `ENTER_B`.
    - operator: replaces `pend_op`.
    - EQ: ignored.
  - `ENTER_B`
    - digit: `acc_b = acc_b*10 + d`.
    - operator or EQ: go to `ALU_REQ`, latching the token kind. For an operator, the new op is saved as `next_op`.
  - `ALU_REQ`: `o_alu_valid=1` with `pend_op`, `acc_a`, `acc_b`; leave on `i_alu_ready`.
  - `ALU_WAIT`: on `i_alu_done`:
    - if `i_alu_err`, go to `ERROR`;
    - otherwise `acc_a = result`, then go to `OP_WAIT` (chained operator, `pend_op = next_op`) or `RESULT` (EQ).
  - `RESULT`
    - digit: `acc_a = d`, go to `ENTER_A`.
    - operator: store `pend_op`, go to `OP_WAIT`.
    - EQ: ignored.
  - `ERROR`: all tokens except AC ignored.
- AC, accepted in any state where `o_ready=1`: clears `acc_a`, `acc_b` and `pend_op`, then goes to `ENTER_A`.
- Digit entry saturation: a digit whose result would exceed 2^(WIDTH-1)−1 is consumed and ignored. The operand is unchanged.
- Display value: `acc_b` in `ENTER_B`, `acc_a` otherwise; `o_disp_err=1` only in `ERROR`.
- Display updates:
  - Any change of `o_disp_value` or `o_disp_err` sets `disp_dirty`.
  - `o_disp_valid = disp_dirty`; it clears on `i_disp_ready`.
  - Value and err stay stable while `o_disp_valid` is high.

## Timing
- Reset values:
  - state `ENTER_A`; all accumulators 0.
  - `o_ready=0`, `o_alu_valid=0`, `o_alu_op=00`, `o_alu_a=0`, `o_alu_b=0`.
  - `o_disp_value=0`, `o_disp_err=0`.
  - `o_disp_valid=1` for one initial update of 0.
- `o_ready` is registered. It is 1 only in `ENTER_A`, `OP_WAIT`, `ENTER_B`, `RESULT` and `ERROR`, and only while `o_disp_valid=0`. Result: at most one token every 2 cycles, and no token is accepted while an update is pending.
- Token effect is visible in registers the cycle after acceptance; `o_disp_valid` asserts in that same cycle.
- Once asserted, `o_alu_valid` holds with stable operands until `i_alu_ready`. There is no timeout.
- An `i_alu_done` pulse is ignored outside `ALU_WAIT`.
- Latency, EQ accept to display update: 2 cycles plus ALU latency.
- Synchronous `rst` mid-operation: state is abandoned immediately, including a pending ALU request. Any late `i_alu_done` is ignored.

## Test plan
- Reset, then tokens 1,2,ADD,3,4,EQ with ALU model returning 46: ALU sees op=00, a=12, b=34; final display 46, err=0.
- 7,SUB,9,EQ with ALU returning −2: display 0xFFFE, `o_disp_err=0`. Then digit 5 gives display 5 (new entry).
- 5,DIV,0,EQ with ALU err=1: display err=1. Digits and EQ ignored. AC gives display 0, err=0.
- Digits 3,2,7,6,8: display 3276 after the 4th digit and stays 3276 after 8 (32768 is saturated away).
- 2,ADD,3,MUL,4,EQ: first ALU request (00,2,3) returns 5. Second request (10,5,4) returns 20; display 20.
- Hold `i_disp_ready=0`: `o_ready` stays 0 and `o_disp_value` stays stable. Assert `rst` during `ALU_WAIT`: all outputs return to reset values and a subsequent `i_alu_done` changes nothing.
